flag_status_unit: RTL and testbench

// - Producer side of the NZCV condition interface: computes flags from execute-stage ALU results and holds them.
// - Drives cond_state[3:0] = {N,Z,C,V} ([3]=N,[2]=Z,[1]=C,[0]=V), the bus condition evaluation in decode reads.
// - Two stages: S1 registers the update and runs zero-detect; S2 commits it to the architectural flag register.
// - Exports a busy/forward pair so decode can stall or bypass conditional instructions behind a flag update.

---
 rtl/flag_status_unit.sv | 124 ++++++++++++
 tb/tb_flag_status_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/flag_status_unit.sv
// NZCV flag producer: S1 captures the flag-setting update, S2 commits it to cond_state.
// Optional FLAG_STATUS_SAVE_EN adds a one-deep save/restore register for the committed flags.
module flag_status_unit #(
    parameter int          DATA_W      = 32,
    parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic              set_flags,
    input  logic              cond_pass,
    input  logic [1:0]        flag_class,
    input  logic [DATA_W-1:0] result,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    input  logic              shifter_carry,
`ifdef FLAG_STATUS_SAVE_EN
    input  logic              save,
    input  logic              restore,
    output logic [3:0]        saved_state,
`endif
    output logic [3:0]        cond_state,
    output logic [3:0]        cond_state_fwd,
    output logic              flags_busy
);

    typedef enum logic [1:0] {
        CLS_LOGICAL = 2'b00,
        CLS_ARITH   = 2'b01,
        CLS_WRITE   = 2'b10,
        CLS_NONE    = 2'b11
    } flag_class_e;

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_result_q;
    logic              s1_alu_carry_q, s1_alu_ovf_q, s1_shf_carry_q;
    flag_class_e       s1_class_q;
    logic [3:0]        s1_flags;
    logic [3:0]        cond_state_q, cond_state_d;
    logic              kill;
    logic              accept;

`ifdef FLAG_STATUS_SAVE_EN
    logic [3:0] saved_state_q, saved_state_d;
    assign kill = flush | restore;
`else
    assign kill = flush;
`endif

    assign accept = ex_valid & set_flags & cond_pass & ~stall & ~kill
                  & (flag_class_e'(flag_class) != CLS_NONE);

    // V for the logical class comes from cond_state at commit time, so the
    // flags are formed from the captured operands rather than stored.
    always_comb begin
        s1_flags = cond_state_q;
        unique case (s1_class_q)
            CLS_LOGICAL: s1_flags = {s1_result_q[DATA_W-1], s1_result_q == '0,
                                     s1_shf_carry_q, cond_state_q[0]};
            CLS_ARITH:   s1_flags = {s1_result_q[DATA_W-1], s1_result_q == '0,
                                     s1_alu_carry_q, s1_alu_ovf_q};
            CLS_WRITE:   s1_flags = s1_result_q[DATA_W-1 -: 4];
            default:     s1_flags = cond_state_q;
        endcase
    end

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        s1_valid_d   = accept;
        cond_state_d = cond_state_q;
        if (s1_valid_q && !flush) cond_state_d = s1_flags;
`ifdef FLAG_STATUS_SAVE_EN
        if (restore) cond_state_d = saved_state_q;
        saved_state_d = saved_state_q;
        if (save && !restore) saved_state_d = cond_state_d;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            cond_state_q <= RESET_FLAGS;
        end else begin
            s1_valid_q   <= s1_valid_d;
            cond_state_q <= cond_state_d;
        end
    end

    // NOTE: S1 operands are reset too so the idle S1 flags equal RESET_FLAGS,
    // making cond_state_fwd well defined out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_result_q    <= {RESET_FLAGS, {(DATA_W-4){1'b0}}};
            s1_class_q     <= CLS_WRITE;
            s1_alu_carry_q <= 1'b0;
            s1_alu_ovf_q   <= 1'b0;
            s1_shf_carry_q <= 1'b0;
        end else if (accept) begin
            s1_result_q    <= result;
            s1_class_q     <= flag_class_e'(flag_class);
            s1_alu_carry_q <= alu_carry;
            s1_alu_ovf_q   <= alu_overflow;
            s1_shf_carry_q <= shifter_carry;
        end
    end

`ifdef FLAG_STATUS_SAVE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) saved_state_q <= RESET_FLAGS;
        else        saved_state_q <= saved_state_d;
    end
    assign saved_state = saved_state_q;
`endif

    assign cond_state     = cond_state_q;
    assign flags_busy     = s1_valid_q;
    assign cond_state_fwd = s1_valid_q ? s1_flags : cond_state_q;

endmodule

// File: tb/tb_flag_status_unit.sv
// Directed bench for flag_status_unit; expected values are hand-computed per scenario.
// Save/restore scenario is compiled only with FLAG_STATUS_SAVE_EN.
module tb_flag_status_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, stall, flush, set_flags, cond_pass;
    logic [1:0]  flag_class;
    logic [31:0] result;
    logic        alu_carry, alu_overflow, shifter_carry;
    logic [3:0]  cond_state, cond_state_fwd;
    logic        flags_busy;
`ifdef FLAG_STATUS_SAVE_EN
    logic        save, restore;
    logic [3:0]  saved_state;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flag_status_unit #(.DATA_W(32), .RESET_FLAGS(4'b0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .stall          (stall),
        .flush          (flush),
        .set_flags      (set_flags),
        .cond_pass      (cond_pass),
        .flag_class     (flag_class),
        .result         (result),
        .alu_carry      (alu_carry),
        .alu_overflow   (alu_overflow),
        .shifter_carry  (shifter_carry),
`ifdef FLAG_STATUS_SAVE_EN
        .save           (save),
        .restore        (restore),
        .saved_state    (saved_state),
`endif
        .cond_state     (cond_state),
        .cond_state_fwd (cond_state_fwd),
        .flags_busy     (flags_busy)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic p, input logic [1:0] c,
                         input logic [31:0] r, input logic ac, input logic ao, input logic sc);
        ex_valid = v; set_flags = s; cond_pass = p; flag_class = c; result = r;
        alu_carry = ac; alu_overflow = ao; shifter_carry = sc;
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 2'b11, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
`ifdef FLAG_STATUS_SAVE_EN
        save = 1'b0; restore = 1'b0;
`endif
        #2;
        checks++; if (cond_state !== 4'b0000) begin errors++; $display("FAIL reset_cond got %b exp 0000", cond_state); end
        checks++; if (flags_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", flags_busy); end
        cycle(); cycle();
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 2'b10, 32'hF000_0000, 1'b0, 1'b0, 1'b0);
        cycle(); idle();
        cycle();
        checks++; if (cond_state !== 4'b1111) begin errors++; $display("FAIL pre_reset_cond got %b exp 1111", cond_state); end
        drive(1'b1, 1'b1, 1'b1, 2'b10, 32'h5000_0000, 1'b0, 1'b0, 1'b0);
        cycle(); idle();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cond_state !== 4'b0000) begin errors++; $display("FAIL async_reset_cond got %b exp 0000", cond_state); end
        checks++; if (flags_busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %b exp 0", flags_busy); end
        checks++; if (cond_state_fwd !== 4'b0000) begin errors++; $display("FAIL async_reset_fwd got %b exp 0000", cond_state_fwd); end
        #1 rst_n = 1'b1;
        cycle();
        checks++; if (cond_state !== 4'b0000) begin errors++; $display("FAIL reset_discard got %b exp 0000", cond_state); end
    endtask

    task automatic test_arith();
        drive(1'b1, 1'b1, 1'b1, 2'b01, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(); idle();
        checks++; if (flags_busy !== 1'b1) begin errors++; $display("FAIL arith_busy got %b exp 1", flags_busy); end
        checks++; if (cond_state !== 4'b0000) begin errors++; $display("FAIL arith_cond_early got %b exp 0000", cond_state); end
        checks++; if (cond_state_fwd !== 4'b0110) begin errors++; $display("FAIL arith_fwd got %b exp 0110", cond_state_fwd); end
        cycle();
        checks++; if (cond_state !== 4'b0110) begin errors++; $display("FAIL arith_cond got %b exp 0110", cond_state); end
        checks++; if (flags_busy !== 1'b0) begin errors++; $display("FAIL arith_busy_clear got %b exp 0", flags_busy); end
    endtask

    task automatic test_logical();
        drive(1'b1, 1'b1, 1'b1, 2'b10, 32'h1000_0000, 1'b0, 1'b0, 1'b0);
        cycle(); idle(); cycle();
        checks++; if (cond_state !== 4'b0001) begin errors++; $display("FAIL write_cond got %b exp 0001", cond_state); end
        // alu carry/overflow set as distractors: logical class must ignore them
        drive(1'b1, 1'b1, 1'b1, 2'b00, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        cycle(); idle(); cycle();
        checks++; if (cond_state !== 4'b1001) begin errors++; $display("FAIL logical_cond got %b exp 1001", cond_state); end
        drive(1'b1, 1'b1, 1'b1, 2'b00, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        cycle(); idle(); cycle();
        checks++; if (cond_state !== 4'b0011) begin errors++; $display("FAIL logical_shc got %b exp 0011", cond_state); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 1'b1, 2'b01, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle();
        checks++; if (cond_state_fwd !== 4'b0100) begin errors++; $display("FAIL b2b_fwd1 got %b exp 0100", cond_state_fwd); end
        checks++; if (cond_state !== 4'b0011) begin errors++; $display("FAIL b2b_cond0 got %b exp 0011", cond_state); end
        drive(1'b1, 1'b1, 1'b1, 2'b10, 32'hF000_0000, 1'b0, 1'b0, 1'b0);
        cycle(); idle();
        checks++; if (cond_state !== 4'b0100) begin errors++; $display("FAIL b2b_cond1 got %b exp 0100", cond_state); end
        checks++; if (cond_state_fwd !== 4'b1111) begin errors++; $display("FAIL b2b_fwd2 got %b exp 1111", cond_state_fwd); end
        checks++; if (flags_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", flags_busy); end
        cycle();
        checks++; if (cond_state !== 4'b1111) begin errors++; $display("FAIL b2b_cond2 got %b exp 1111", cond_state); end
        checks++; if (flags_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_clear got %b exp 0", flags_busy); end
    endtask

    task automatic test_flush_stall();
        drive(1'b1, 1'b1, 1'b1, 2'b01, 32'h1, 1'b0, 1'b0, 1'b0);
        cycle(); idle(); flush = 1'b1;
        cycle(); flush = 1'b0;
        checks++; if (cond_state !== 4'b1111) begin errors++; $display("FAIL flush_cond got %b exp 1111", cond_state); end
        checks++; if (flags_busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", flags_busy); end
        drive(1'b1, 1'b1, 1'b1, 2'b01, 32'h0, 1'b0, 1'b0, 1'b0); flush = 1'b1;
        cycle(); idle();
        checks++; if (flags_busy !== 1'b0) begin errors++; $display("FAIL flush_accept_busy got %b exp 0", flags_busy); end
        drive(1'b1, 1'b1, 1'b1, 2'b01, 32'h0, 1'b0, 1'b0, 1'b0); stall = 1'b1;
        cycle(); idle();
        checks++; if (flags_busy !== 1'b0) begin errors++; $display("FAIL stall_accept_busy got %b exp 0", flags_busy); end
        drive(1'b1, 1'b1, 1'b1, 2'b01, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle();
        stall = 1'b1;
        cycle(); idle();
        checks++; if (cond_state !== 4'b0100) begin errors++; $display("FAIL stall_commit got %b exp 0100", cond_state); end
        checks++; if (flags_busy !== 1'b0) begin errors++; $display("FAIL stall_busy got %b exp 0", flags_busy); end
    endtask

    task automatic test_gating();
        drive(1'b1, 1'b1, 1'b0, 2'b10, 32'hF000_0000, 1'b0, 1'b0, 1'b0);
        cycle();
        checks++; if (flags_busy !== 1'b0) begin errors++; $display("FAIL condfail_busy got %b exp 0", flags_busy); end
        drive(1'b1, 1'b0, 1'b1, 2'b10, 32'hF000_0000, 1'b0, 1'b0, 1'b0);
        cycle();
        checks++; if (flags_busy !== 1'b0) begin errors++; $display("FAIL sbit_busy got %b exp 0", flags_busy); end
        drive(1'b1, 1'b1, 1'b1, 2'b11, 32'hF000_0000, 1'b1, 1'b1, 1'b1);
        cycle();
        checks++; if (flags_busy !== 1'b0) begin errors++; $display("FAIL none_busy got %b exp 0", flags_busy); end
        drive(1'b0, 1'b1, 1'b1, 2'b10, 32'hF000_0000, 1'b0, 1'b0, 1'b0);
        cycle(); idle(); cycle();
        checks++; if (cond_state !== 4'b0100) begin errors++; $display("FAIL gating_cond got %b exp 0100", cond_state); end
    endtask

`ifdef FLAG_STATUS_SAVE_EN
    task automatic test_save_restore();
        drive(1'b1, 1'b1, 1'b1, 2'b10, 32'hA000_0000, 1'b0, 1'b0, 1'b0);
        cycle(); idle(); save = 1'b1;
        cycle(); save = 1'b0;
        checks++; if (saved_state !== 4'b1010) begin errors++; $display("FAIL save_commit got %b exp 1010", saved_state); end
        drive(1'b1, 1'b1, 1'b1, 2'b01, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(); idle(); cycle();
        checks++; if (cond_state !== 4'b0100) begin errors++; $display("FAIL sr_update got %b exp 0100", cond_state); end
        restore = 1'b1;
        cycle(); restore = 1'b0;
        checks++; if (cond_state !== 4'b1010) begin errors++; $display("FAIL restore_cond got %b exp 1010", cond_state); end
        drive(1'b1, 1'b1, 1'b1, 2'b01, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(); idle(); save = 1'b1; restore = 1'b1;
        cycle(); save = 1'b0; restore = 1'b0;
        checks++; if (cond_state !== 4'b1010) begin errors++; $display("FAIL restore_beats_commit got %b exp 1010", cond_state); end
        checks++; if (saved_state !== 4'b1010) begin errors++; $display("FAIL save_restore_saved got %b exp 1010", saved_state); end
        checks++; if (flags_busy !== 1'b0) begin errors++; $display("FAIL restore_kill got %b exp 0", flags_busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_logical();
        test_back_to_back();
        test_flush_stall();
        test_gating();
`ifdef FLAG_STATUS_SAVE_EN
        test_save_restore();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
